// File: rtl/game_pkg.sv
// Shared encodings and helpers for the breakout game-flow controller.
// Also holds the BCD digit width and the default frame constants.
package game_pkg;

   typedef enum logic [2:0] {
      ATTRACT     = 3'd0,
      SERVE       = 3'd1,
      PLAY        = 3'd2,
      PAUSE       = 3'd3,
      LEVEL_CLEAR = 3'd4,
      GAME_OVER   = 3'd5
   } state_t;

   localparam int BCD_W            = 4;
   localparam int DEF_LIVES        = 3;
   localparam int DEF_LEVELS       = 4;
   localparam int DEF_SERVE_FRAMES = 60;
   localparam int DEF_CLEAR_FRAMES = 90;

   // Adds a digit and an addend (each 0..9).
   // Returns {carry, corrected digit}.
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] d, input logic [3:0] a);
      logic [4:0] s;
      s = {1'b0, d} + {1'b0, a};
      if (s > 5'd9) s = s + 5'd6;
      return s;
   endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Parametrised BCD score accumulator: ripple add of a one-digit addend.
// Saturates to all nines when a carry leaves the top digit.
module bcd_score_counter
   import game_pkg::*;
#(
   parameter int SCORE_DIGITS = 4
) (
   input  logic                            clk,
   input  logic                            nRst,
   input  logic                            clr,
   input  logic                            add_en,
   input  logic [3:0]                      addend,
   output logic [BCD_W*SCORE_DIGITS-1:0]   score,
   output logic                            saturation
);

   localparam int SW = BCD_W * SCORE_DIGITS;

   logic [SW-1:0] sum_next;
   logic [3:0]    carry;
   logic [4:0]    dsum;
   logic          top_carry;

   always_comb begin
      sum_next = '0;
      carry    = addend;
      dsum     = '0;
      for (int i = 0; i < SCORE_DIGITS; i++) begin
         dsum = bcd_digit_add(score[i*BCD_W +: BCD_W], carry);
         sum_next[i*BCD_W +: BCD_W] = dsum[3:0];
         carry = {3'b000, dsum[4]};
      end
      top_carry = carry[0];
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         score      <= '0;
         saturation <= 1'b0;
      end else if (clr) begin
         score      <= '0;
         saturation <= 1'b0;
      end else if (add_en && !saturation) begin
         if (top_carry) begin
            score      <= {SCORE_DIGITS{4'h9}};
            saturation <= 1'b1;
         end else begin
            score      <= sum_next;
         end
      end
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// Breakout game-flow controller: attract/serve/play/pause/level-clear/game-over,
// with lives, level and BCD score. All outputs are registered.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int LIVES        = DEF_LIVES,
   parameter int LIVES_W      = 2,
   parameter int LEVELS       = DEF_LEVELS,
   parameter int LEVEL_W      = 2,
   parameter int SCORE_DIGITS = 4,
   parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
   parameter int CLEAR_FRAMES = DEF_CLEAR_FRAMES
) (
   input  logic                           clk,
   input  logic                           nRst,
   input  logic                           en,
   input  logic                           frame_pulse,
   input  logic                           btn_select,
   input  logic                           block_hit,
   input  logic                           ball_lost,
   input  logic                           field_clear,
   output logic [2:0]                     state,
   output logic                           do_move,
   output logic                           ball_reset,
   output logic                           field_reset,
   output logic [LIVES_W-1:0]             lives,
   output logic [LEVEL_W-1:0]             level,
   output logic [BCD_W*SCORE_DIGITS-1:0]  score
);

   localparam int TMAX    = (SERVE_FRAMES > CLEAR_FRAMES) ? SERVE_FRAMES : CLEAR_FRAMES;
   localparam int TIMER_W = $clog2(TMAX + 1);

   state_t             st;
   logic [TIMER_W-1:0] timer;
   logic               sync1, sync2, sync3;
   logic               sel_edge;
   logic               score_clr, score_add, score_sat;
   logic [3:0]         addend;

   // {do_move, ball_reset} while resident in a state
   function automatic logic [1:0] mode_outs(input state_t s);
      case (s)
         SERVE:   return 2'b11;
         PLAY:    return 2'b10;
         PAUSE:   return 2'b00;
         default: return 2'b01;
      endcase
   endfunction

   assign state     = st;
   assign sel_edge  = sync2 & ~sync3;
   assign score_clr = en && (st == ATTRACT) && sel_edge;
   assign score_add = en && (st == PLAY) && block_hit && !score_sat;
   assign addend    = 4'(level) + 4'd1;

   bcd_score_counter #(
      .SCORE_DIGITS (SCORE_DIGITS)
   ) u_score (
      .clk        (clk),
      .nRst       (nRst),
      .clr        (score_clr),
      .add_en     (score_add),
      .addend     (addend),
      .score      (score),
      .saturation (score_sat)
   );

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         sync3       <= 1'b0;
         st          <= ATTRACT;
         do_move     <= 1'b0;
         ball_reset  <= 1'b1;
         field_reset <= 1'b0;
         lives       <= LIVES_W'(LIVES);
         level       <= '0;
         timer       <= '0;
      end else begin
         sync1       <= btn_select;
         sync2       <= sync1;
         sync3       <= sync2;
         field_reset <= 1'b0;
         if (!en) begin
            do_move <= 1'b0;
         end else begin
            // Stay-in-state outputs; transitions below override them.
            {do_move, ball_reset} <= mode_outs(st);
            case (st)
               ATTRACT: begin
                  if (sel_edge) begin
                     lives                 <= LIVES_W'(LIVES);
                     level                 <= '0;
                     field_reset           <= 1'b1;
                     timer                 <= TIMER_W'(SERVE_FRAMES);
                     st                    <= SERVE;
                     {do_move, ball_reset} <= mode_outs(SERVE);
                  end
               end
               SERVE: begin
                  if (sel_edge || (frame_pulse && timer <= TIMER_W'(1))) begin
                     timer                 <= '0;
                     st                    <= PLAY;
                     {do_move, ball_reset} <= mode_outs(PLAY);
                  end else if (frame_pulse) begin
                     timer <= timer - TIMER_W'(1);
                  end
               end
               PLAY: begin
                  if (field_clear) begin
                     timer                 <= TIMER_W'(CLEAR_FRAMES);
                     st                    <= LEVEL_CLEAR;
                     {do_move, ball_reset} <= mode_outs(LEVEL_CLEAR);
                  end else if (ball_lost) begin
                     if (lives <= LIVES_W'(1)) begin
                        lives                 <= '0;
                        st                    <= GAME_OVER;
                        {do_move, ball_reset} <= mode_outs(GAME_OVER);
                     end else begin
                        lives                 <= lives - LIVES_W'(1);
                        timer                 <= TIMER_W'(SERVE_FRAMES);
                        st                    <= SERVE;
                        {do_move, ball_reset} <= mode_outs(SERVE);
                     end
                  end else if (sel_edge) begin
                     st                    <= PAUSE;
                     {do_move, ball_reset} <= mode_outs(PAUSE);
                  end
               end
               PAUSE: begin
                  if (sel_edge) begin
                     st                    <= PLAY;
                     {do_move, ball_reset} <= mode_outs(PLAY);
                  end
               end
               LEVEL_CLEAR: begin
                  if (frame_pulse && timer <= TIMER_W'(1)) begin
                     if (level != LEVEL_W'(LEVELS - 1)) level <= level + LEVEL_W'(1);
                     field_reset           <= 1'b1;
                     timer                 <= TIMER_W'(SERVE_FRAMES);
                     st                    <= SERVE;
                     {do_move, ball_reset} <= mode_outs(SERVE);
                  end else if (frame_pulse) begin
                     timer <= timer - TIMER_W'(1);
                  end
               end
               GAME_OVER: begin
                  if (sel_edge) begin
                     st                    <= ATTRACT;
                     {do_move, ball_reset} <= mode_outs(ATTRACT);
                  end
               end
               default: begin
                  st                    <= ATTRACT;
                  {do_move, ball_reset} <= mode_outs(ATTRACT);
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: reset, serve timing, a table-driven game
// script, enable freeze, asynchronous reset and standalone score saturation.
module tb_game_flow_ctrl;

   logic        clk = 1'b0;
   logic        nRst, en, frame_pulse, btn_select, block_hit, ball_lost, field_clear;
   logic [2:0]  state;
   logic        do_move, ball_reset, field_reset;
   logic [1:0]  lives, level;
   logic [15:0] score;

   logic        bcd_clr, bcd_add, bcd_sat;
   logic [3:0]  bcd_addend;
   logic [15:0] bcd_score;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   game_flow_ctrl dut (
      .clk         (clk),
      .nRst        (nRst),
      .en          (en),
      .frame_pulse (frame_pulse),
      .btn_select  (btn_select),
      .block_hit   (block_hit),
      .ball_lost   (ball_lost),
      .field_clear (field_clear),
      .state       (state),
      .do_move     (do_move),
      .ball_reset  (ball_reset),
      .field_reset (field_reset),
      .lives       (lives),
      .level       (level),
      .score       (score)
   );

   bcd_score_counter #(.SCORE_DIGITS(4)) u_bcd (
      .clk        (clk),
      .nRst       (nRst),
      .clr        (bcd_clr),
      .add_en     (bcd_add),
      .addend     (bcd_addend),
      .score      (bcd_score),
      .saturation (bcd_sat)
   );

   typedef struct {
      logic [3:0]  ev;      // {select, field_clear, ball_lost, block_hit}
      int          frames;
      logic [2:0]  st;
      logic [1:0]  lv;
      logic [1:0]  lev;
      logic [15:0] sc;
      logic        fr;
   } vec_t;

   vec_t vecs[30];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_frame;
      frame_pulse = 1'b1;
      tick();
      frame_pulse = 1'b0;
   endtask

   task automatic press;
      btn_select = 1'b1;
      tick();
      btn_select = 1'b0;
      tick();
      tick();
   endtask

   task automatic apply_vec(input int i);
      if (vecs[i].ev[3]) begin
         press();
      end else if (vecs[i].ev[2:0] != 3'b000) begin
         {field_clear, ball_lost, block_hit} = vecs[i].ev[2:0];
         tick();
         {field_clear, ball_lost, block_hit} = 3'b000;
      end
      repeat (vecs[i].frames) pulse_frame();
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("v%0d_lives", i), 32'(lives), 32'(vecs[i].lv));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].lev));
      chk($sformatf("v%0d_score", i), 32'(score), 32'(vecs[i].sc));
      chk($sformatf("v%0d_frst", i), 32'(field_reset), 32'(vecs[i].fr));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           ev       fr  st    lv    lev   score     frst
      vecs[0]  = '{4'b0001, 0,  3'd2, 2'd3, 2'd0, 16'h0001, 1'b0};
      vecs[1]  = '{4'b0001, 0,  3'd2, 2'd3, 2'd0, 16'h0002, 1'b0};
      vecs[2]  = '{4'b0100, 0,  3'd4, 2'd3, 2'd0, 16'h0002, 1'b0};
      vecs[3]  = '{4'b0000, 90, 3'd1, 2'd3, 2'd1, 16'h0002, 1'b1};
      vecs[4]  = '{4'b0000, 60, 3'd2, 2'd3, 2'd1, 16'h0002, 1'b0};
      vecs[5]  = '{4'b0001, 0,  3'd2, 2'd3, 2'd1, 16'h0004, 1'b0};
      vecs[6]  = '{4'b0100, 0,  3'd4, 2'd3, 2'd1, 16'h0004, 1'b0};
      vecs[7]  = '{4'b0000, 90, 3'd1, 2'd3, 2'd2, 16'h0004, 1'b1};
      vecs[8]  = '{4'b1000, 0,  3'd2, 2'd3, 2'd2, 16'h0004, 1'b0};
      vecs[9]  = '{4'b0001, 0,  3'd2, 2'd3, 2'd2, 16'h0007, 1'b0};
      vecs[10] = '{4'b0001, 0,  3'd2, 2'd3, 2'd2, 16'h0010, 1'b0};
      vecs[11] = '{4'b0001, 0,  3'd2, 2'd3, 2'd2, 16'h0013, 1'b0};
      vecs[12] = '{4'b0001, 0,  3'd2, 2'd3, 2'd2, 16'h0016, 1'b0};
      vecs[13] = '{4'b0010, 0,  3'd1, 2'd2, 2'd2, 16'h0016, 1'b0};
      vecs[14] = '{4'b1000, 0,  3'd2, 2'd2, 2'd2, 16'h0016, 1'b0};
      vecs[15] = '{4'b0111, 0,  3'd4, 2'd2, 2'd2, 16'h0019, 1'b0};
      vecs[16] = '{4'b0000, 90, 3'd1, 2'd2, 2'd3, 16'h0019, 1'b1};
      vecs[17] = '{4'b1000, 0,  3'd2, 2'd2, 2'd3, 16'h0019, 1'b0};
      vecs[18] = '{4'b0100, 0,  3'd4, 2'd2, 2'd3, 16'h0019, 1'b0};
      vecs[19] = '{4'b0000, 90, 3'd1, 2'd2, 2'd3, 16'h0019, 1'b1};
      vecs[20] = '{4'b1000, 0,  3'd2, 2'd2, 2'd3, 16'h0019, 1'b0};
      vecs[21] = '{4'b0001, 0,  3'd2, 2'd2, 2'd3, 16'h0023, 1'b0};
      vecs[22] = '{4'b1000, 0,  3'd3, 2'd2, 2'd3, 16'h0023, 1'b0};
      vecs[23] = '{4'b0011, 0,  3'd3, 2'd2, 2'd3, 16'h0023, 1'b0};
      vecs[24] = '{4'b1000, 0,  3'd2, 2'd2, 2'd3, 16'h0023, 1'b0};
      vecs[25] = '{4'b0010, 0,  3'd1, 2'd1, 2'd3, 16'h0023, 1'b0};
      vecs[26] = '{4'b1000, 0,  3'd2, 2'd1, 2'd3, 16'h0023, 1'b0};
      vecs[27] = '{4'b0011, 0,  3'd5, 2'd0, 2'd3, 16'h0027, 1'b0};
      vecs[28] = '{4'b1000, 0,  3'd0, 2'd0, 2'd3, 16'h0027, 1'b0};
      vecs[29] = '{4'b1000, 0,  3'd1, 2'd3, 2'd0, 16'h0000, 1'b1};

      nRst = 1'b0; en = 1'b1; frame_pulse = 1'b0; btn_select = 1'b0;
      block_hit = 1'b0; ball_lost = 1'b0; field_clear = 1'b0;
      bcd_clr = 1'b0; bcd_add = 1'b0; bcd_addend = 4'd0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_do_move", 32'(do_move), 32'd0);
      chk("rst_ball_reset", 32'(ball_reset), 32'd1);
      chk("rst_field_reset", 32'(field_reset), 32'd0);
      chk("rst_lives", 32'(lives), 32'd3);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      nRst = 1'b1;
      tick();
      chk("rel_state", 32'(state), 32'd0);
      chk("rel_field_reset", 32'(field_reset), 32'd0);

      // Select latency: state changes on the third edge after the rise
      btn_select = 1'b1;
      tick();
      btn_select = 1'b0;
      tick();
      chk("sel_lat2_state", 32'(state), 32'd0);
      tick();
      chk("sel_lat3_state", 32'(state), 32'd1);
      chk("start_field_reset", 32'(field_reset), 32'd1);
      chk("start_lives", 32'(lives), 32'd3);
      chk("start_score", 32'(score), 32'd0);
      chk("serve_do_move", 32'(do_move), 32'd1);
      chk("serve_ball_reset", 32'(ball_reset), 32'd1);
      tick();
      chk("start_field_reset_1cyc", 32'(field_reset), 32'd0);

      // Auto-serve after 60 frames
      repeat (59) pulse_frame();
      chk("serve59_state", 32'(state), 32'd1);
      pulse_frame();
      chk("serve60_state", 32'(state), 32'd2);
      chk("play_do_move", 32'(do_move), 32'd1);
      chk("play_ball_reset", 32'(ball_reset), 32'd0);

      for (int i = 0; i < 30; i++) apply_vec(i);

      // en=0 in SERVE freezes the timer and forces do_move low
      repeat (30) pulse_frame();
      en = 1'b0;
      tick();
      chk("en0_do_move", 32'(do_move), 32'd0);
      repeat (50) pulse_frame();
      chk("en0_serve_state", 32'(state), 32'd1);
      en = 1'b1;
      tick();
      chk("en1_do_move", 32'(do_move), 32'd1);
      repeat (29) pulse_frame();
      chk("en_timer_held_state", 32'(state), 32'd1);
      pulse_frame();
      chk("en_timer_done_state", 32'(state), 32'd2);

      // Pause, then en=0 with events and a press that must be discarded
      press();
      chk("pause_state", 32'(state), 32'd3);
      chk("pause_do_move", 32'(do_move), 32'd0);
      chk("pause_ball_reset", 32'(ball_reset), 32'd0);
      en = 1'b0;
      repeat (100) pulse_frame();
      {ball_lost, block_hit} = 2'b11;
      tick();
      {ball_lost, block_hit} = 2'b00;
      press();
      en = 1'b1;
      tick();
      tick();
      chk("frz_state", 32'(state), 32'd3);
      chk("frz_lives", 32'(lives), 32'd3);
      chk("frz_score", 32'(score), 32'd0);
      chk("frz_level", 32'(level), 32'd0);
      chk("frz_do_move", 32'(do_move), 32'd0);
      chk("frz_field_reset", 32'(field_reset), 32'd0);
      ball_lost = 1'b1;
      tick();
      ball_lost = 1'b0;
      chk("pause_lost_ignored", 32'(lives), 32'd3);
      press();
      chk("resume_state", 32'(state), 32'd2);
      chk("resume_do_move", 32'(do_move), 32'd1);

      // Asynchronous reset in PLAY
      block_hit = 1'b1;
      tick();
      block_hit = 1'b0;
      chk("pre_rst_score", 32'(score), 32'h0001);
      #3;
      nRst = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_do_move", 32'(do_move), 32'd0);
      chk("arst_ball_reset", 32'(ball_reset), 32'd1);
      chk("arst_lives", 32'(lives), 32'd3);
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_score", 32'(score), 32'd0);
      #2;
      nRst = 1'b1;
      tick();
      chk("arst_rel_state", 32'(state), 32'd0);
      chk("arst_rel_frst", 32'(field_reset), 32'd0);
      tick();
      chk("arst_rel_frst2", 32'(field_reset), 32'd0);

      // Standalone score counter: carry chain and saturation
      chk("bcd_init", 32'(bcd_score), 32'd0);
      bcd_add = 1'b1;
      bcd_addend = 4'd9;
      tick();
      tick();
      chk("bcd_18", 32'(bcd_score), 32'h0018);
      repeat (1108) tick();
      chk("bcd_9990", 32'(bcd_score), 32'h9990);
      bcd_addend = 4'd8;
      tick();
      chk("bcd_9998", 32'(bcd_score), 32'h9998);
      bcd_addend = 4'd1;
      tick();
      chk("bcd_9999", 32'(bcd_score), 32'h9999);
      chk("bcd_not_sat", 32'(bcd_sat), 32'd0);
      tick();
      chk("bcd_sat_score", 32'(bcd_score), 32'h9999);
      chk("bcd_sat_flag", 32'(bcd_sat), 32'd1);
      bcd_addend = 4'd5;
      tick();
      chk("bcd_sat_hold", 32'(bcd_score), 32'h9999);
      bcd_add = 1'b0;
      bcd_clr = 1'b1;
      tick();
      bcd_clr = 1'b0;
      chk("bcd_clr_score", 32'(bcd_score), 32'd0);
      chk("bcd_clr_sat", 32'(bcd_sat), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
